// File: rtl/can_len_pkg.sv
// -----------------------------------------------------------------------------
// can_len_pkg
// Shared definitions for CAN data-length handling on the receive and
// transmit sides:
//   - state_t          : receive length controller states (S_IDLE/S_COUNT/S_DONE)
//   - CLASSIC_MAX_LEN  : byte count that classic DLC values 9..15 saturate to
//   - FD_LEN_TAB       : CAN FD byte lengths for DLC 9..15
//   - fd_len()         : DLC -> byte length under the CAN FD table
// -----------------------------------------------------------------------------
package can_len_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COUNT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam int unsigned CLASSIC_MAX_LEN = 8;

   // DLC 9..15 in FD frames
   localparam int unsigned FD_TAB_BASE = 9;
   localparam int unsigned FD_TAB_SIZE = 7;
   localparam int unsigned FD_LEN_TAB [FD_TAB_SIZE] = '{12, 16, 20, 24, 32, 48, 64};

   function automatic int unsigned fd_len(input int unsigned d);
      int unsigned r;
      if (d < FD_TAB_BASE)
         r = d;
      else if ((d - FD_TAB_BASE) < FD_TAB_SIZE)
         r = FD_LEN_TAB[d - FD_TAB_BASE];
      else
         r = FD_LEN_TAB[FD_TAB_SIZE-1];
      return r;
   endfunction

endpackage

// File: rtl/rx_len_ctrl_dlc2len.sv
// -----------------------------------------------------------------------------
// dlc2len
// Combinational DLC -> byte length conversion, shared by receive and transmit.
// Optional feature: CANAKARI_RMLEN_FD_EN enables the CAN FD length table and
// the fdf&rtr error; without it fdf is ignored and only the classic clamp
// applies.
// Ports:
//   dlc  in  DLC_W  data length code
//   rtr  in  1      remote frame (length forced to 0)
//   fdf  in  1      FD frame flag
//   len  out LEN_W  byte length
//   err  out 1      illegal combination (FD remote frame)
// -----------------------------------------------------------------------------
module dlc2len
   import can_len_pkg::*;
#(
   parameter int unsigned DLC_W = 4,
   parameter int unsigned LEN_W = 7
) (
   input  logic [DLC_W-1:0] dlc,
   input  logic             rtr,
   input  logic             fdf,
   output logic [LEN_W-1:0] len,
   output logic             err
);

   int unsigned d_val;
   int unsigned l_val;

`ifdef CANAKARI_RMLEN_FD_EN
   always_comb begin
      d_val = 32'(dlc);
      l_val = 0;
      err   = 1'b0;
      if (rtr) begin
         l_val = 0;
         err   = fdf;
      end else if (fdf) begin
         l_val = fd_len(d_val);
      end else begin
         l_val = (d_val > CLASSIC_MAX_LEN) ? CLASSIC_MAX_LEN : d_val;
      end
      len = LEN_W'(l_val);
   end
`else
   logic unused_fdf;
   assign unused_fdf = fdf;

   always_comb begin
      d_val = 32'(dlc);
      l_val = 0;
      err   = 1'b0;
      if (!rtr)
         l_val = (d_val > CLASSIC_MAX_LEN) ? CLASSIC_MAX_LEN : d_val;
      len = LEN_W'(l_val);
   end
`endif

endmodule

// File: rtl/rx_len_ctrl.sv
// -----------------------------------------------------------------------------
// rx_len_ctrl
// Receive data-length controller: assembles the DLC bit by bit from macfsm
// capture strobes, converts it to a byte length at lock, then counts received
// data bytes down to the last one.
// Optional feature: CANAKARI_RMLEN_FD_EN (FD length table, see dlc2len).
// Ports:
//   clock      in  1      system clock, rising edge
//   reset      in  1      asynchronous reset, active high
//   clr        in  1      synchronous clear (start of frame / abort)
//   activ      in  1      capture strobe level, rising edge detected here
//   setidx     in  IDX_W  1..DLC_W selects dlc[setidx-1], else no-op
//   dlc_bit    in  1      value written to the selected DLC bit
//   rtr        in  1      remote frame flag, sampled at lock
//   fdf        in  1      FD frame flag, sampled at lock
//   lock       in  1      end of DLC field pulse
//   byte_done  in  1      one data byte received pulse
//   dlc        out DLC_W  assembled DLC
//   rmlb       out LEN_W  effective data length in bytes
//   len_valid  out 1      rmlb valid
//   bytes_left out LEN_W  bytes still expected
//   last_byte  out 1      counting and one byte left
//   len_err    out 1      sticky error (overrun / FD remote frame)
// -----------------------------------------------------------------------------
module rx_len_ctrl
   import can_len_pkg::*;
#(
   parameter int unsigned DLC_W = 4,
   parameter int unsigned IDX_W = 3,
   parameter int unsigned LEN_W = 7
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clr,
   input  logic             activ,
   input  logic [IDX_W-1:0] setidx,
   input  logic             dlc_bit,
   input  logic             rtr,
   input  logic             fdf,
   input  logic             lock,
   input  logic             byte_done,
   output logic [DLC_W-1:0] dlc,
   output logic [LEN_W-1:0] rmlb,
   output logic             len_valid,
   output logic [LEN_W-1:0] bytes_left,
   output logic             last_byte,
   output logic             len_err
);

   state_t             state_q, state_n;
   logic               activ_d_q, activ_d_n;
   logic [DLC_W-1:0]   dlc_q, dlc_n;
   logic [LEN_W-1:0]   rmlb_q, rmlb_n;
   logic [LEN_W-1:0]   left_q, left_n;
   logic               valid_q, valid_n;
   logic               err_q, err_n;

   logic               edge_det;
   logic [LEN_W-1:0]   len_c;
   logic               len_err_c;

   assign edge_det = activ & ~activ_d_q;

   dlc2len #(
      .DLC_W (DLC_W),
      .LEN_W (LEN_W)
   ) u_dlc2len (
      .dlc (dlc_q),
      .rtr (rtr),
      .fdf (fdf),
      .len (len_c),
      .err (len_err_c)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         activ_d_q <= 1'b0;
         dlc_q     <= '0;
         rmlb_q    <= '0;
         left_q    <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_n;
         activ_d_q <= activ_d_n;
         dlc_q     <= dlc_n;
         rmlb_q    <= rmlb_n;
         left_q    <= left_n;
         valid_q   <= valid_n;
         err_q     <= err_n;
      end
   end

   always_comb begin
      state_n   = state_q;
      activ_d_n = activ;
      dlc_n     = dlc_q;
      rmlb_n    = rmlb_q;
      left_n    = left_q;
      err_n     = err_q;

      if (clr) begin
         state_n   = S_IDLE;
         activ_d_n = 1'b0;
         dlc_n     = '0;
         rmlb_n    = '0;
         left_n    = '0;
         err_n     = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               // lock wins over a same-cycle DLC write and a stray byte_done:
               // the length is taken from the DLC as it stood before this edge.
               if (lock) begin
                  rmlb_n = len_c;
                  err_n  = err_q | len_err_c;
                  if (len_c != '0) begin
                     state_n = S_COUNT;
                     left_n  = len_c;
                  end else begin
                     state_n = S_DONE;
                  end
               end else begin
                  if (edge_det) begin
                     for (int unsigned i = 0; i < DLC_W; i++) begin
                        if (32'(setidx) == i + 1)
                           dlc_n[i] = dlc_bit;
                     end
                  end
                  if (byte_done)
                     err_n = 1'b1;
               end
            end
            S_COUNT: begin
               if (byte_done) begin
                  if (left_q == LEN_W'(1)) begin
                     state_n = S_DONE;
                     left_n  = '0;
                  end else begin
                     left_n = left_q - LEN_W'(1);
                  end
               end
            end
            S_DONE: begin
               if (byte_done)
                  err_n = 1'b1;
            end
            default: state_n = S_IDLE;
         endcase
      end

      valid_n = (state_n != S_IDLE);
   end

   assign dlc        = dlc_q;
   assign rmlb       = rmlb_q;
   assign len_valid  = valid_q;
   assign bytes_left = left_q;
   assign len_err    = err_q;
   assign last_byte  = (state_q == S_COUNT) && (left_q == LEN_W'(1));

endmodule

// File: tb/tb_rx_len_ctrl.sv
module tb_rx_len_ctrl;

   localparam int unsigned DLC_W = 4;
   localparam int unsigned IDX_W = 3;
   localparam int unsigned LEN_W = 7;

`ifdef CANAKARI_RMLEN_FD_EN
   localparam int unsigned EXP_FD_C   = 24;
   localparam int unsigned EXP_FD_F   = 64;
   localparam logic        EXP_FD_ERR = 1'b1;
`else
   localparam int unsigned EXP_FD_C   = 8;
   localparam int unsigned EXP_FD_F   = 8;
   localparam logic        EXP_FD_ERR = 1'b0;
`endif

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             clr = 1'b0;
   logic             activ = 1'b0;
   logic [IDX_W-1:0] setidx = '0;
   logic             dlc_bit = 1'b0;
   logic             rtr = 1'b0;
   logic             fdf = 1'b0;
   logic             lock = 1'b0;
   logic             byte_done = 1'b0;
   logic [DLC_W-1:0] dlc;
   logic [LEN_W-1:0] rmlb;
   logic             len_valid;
   logic [LEN_W-1:0] bytes_left;
   logic             last_byte;
   logic             len_err;

   rx_len_ctrl #(
      .DLC_W (DLC_W),
      .IDX_W (IDX_W),
      .LEN_W (LEN_W)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .clr        (clr),
      .activ      (activ),
      .setidx     (setidx),
      .dlc_bit    (dlc_bit),
      .rtr        (rtr),
      .fdf        (fdf),
      .lock       (lock),
      .byte_done  (byte_done),
      .dlc        (dlc),
      .rmlb       (rmlb),
      .len_valid  (len_valid),
      .bytes_left (bytes_left),
      .last_byte  (last_byte),
      .len_err    (len_err)
   );

   always #5 clock = ~clock;

   typedef struct {
      string name;
      int    dlc;
      int    rmlb;
      int    lv;
      int    bl;
      int    lb;
      int    err;
   } exp_t;

   exp_t exp_q[$];
   int   tests_run = 0;
   int   tests_failed = 0;

   task automatic expect_out(input string name, input int d, input int r, input int lv,
                             input int bl, input int lb, input int e);
      exp_t x;
      x.name = name; x.dlc = d; x.rmlb = r; x.lv = lv; x.bl = bl; x.lb = lb; x.err = e;
      exp_q.push_back(x);
   endtask

   // Monitor: outputs are sampled on the falling edge, away from the active edge.
   initial begin
      forever begin
         @(negedge clock);
         while (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            tests_run++;
            if (int'(dlc) != x.dlc || int'(rmlb) != x.rmlb || int'(len_valid) != x.lv ||
                int'(bytes_left) != x.bl || int'(last_byte) != x.lb || int'(len_err) != x.err) begin
               tests_failed++;
               $display("FAIL %s: got dlc=%0d rmlb=%0d len_valid=%0d bytes_left=%0d last_byte=%0d len_err=%0d, expected dlc=%0d rmlb=%0d len_valid=%0d bytes_left=%0d last_byte=%0d len_err=%0d",
                        x.name, dlc, rmlb, len_valid, bytes_left, last_byte, len_err,
                        x.dlc, x.rmlb, x.lv, x.bl, x.lb, x.err);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic write_bit(input int idx, input logic b);
      setidx  = IDX_W'(idx);
      dlc_bit = b;
      activ   = 1'b1;
      cyc();
      activ   = 1'b0;
      cyc();
   endtask

   task automatic pulse_lock();
      lock = 1'b1;
      cyc();
      lock = 1'b0;
   endtask

   task automatic pulse_byte();
      byte_done = 1'b1;
      cyc();
      byte_done = 1'b0;
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      cyc();
      clr = 1'b0;
   endtask

   initial begin
      cyc();
      cyc();
      reset = 1'b0;
      expect_out("reset_state", 0, 0, 0, 0, 0, 0);
      cyc();

      // Frame of 5 bytes, DLC assembled bit by bit
      write_bit(1, 1'b1);
      write_bit(2, 1'b0);
      write_bit(3, 1'b1);
      write_bit(4, 1'b0);
      expect_out("dlc_assembled", 5, 0, 0, 0, 0, 0);
      pulse_lock();
      expect_out("lock_dlc5", 5, 5, 1, 5, 0, 0);
      for (int i = 0; i < 4; i++) pulse_byte();
      expect_out("last_byte_before_5th", 5, 5, 1, 1, 1, 0);
      pulse_byte();
      expect_out("done_after_5", 5, 5, 1, 0, 0, 0);
      pulse_clr();
      expect_out("clr_after_frame", 0, 0, 0, 0, 0, 0);

      // Remote frame, then overrun
      for (int i = 1; i <= 4; i++) write_bit(i, 1'b1);
      rtr = 1'b1;
      pulse_lock();
      rtr = 1'b0;
      expect_out("rtr_lock", 15, 0, 1, 0, 0, 0);
      pulse_byte();
      expect_out("overrun_err", 15, 0, 1, 0, 0, 1);
      cyc();
      expect_out("err_sticky", 15, 0, 1, 0, 0, 1);
      pulse_clr();
      expect_out("clr_err", 0, 0, 0, 0, 0, 0);

      // Overrun in IDLE
      pulse_byte();
      expect_out("idle_overrun", 0, 0, 0, 0, 0, 1);
      pulse_clr();

      // Length mapping of large DLC values
      write_bit(3, 1'b1);
      write_bit(4, 1'b1);
      pulse_lock();
      expect_out("classic_dlc_c", 12, 8, 1, 8, 0, 0);
      pulse_clr();
      write_bit(3, 1'b1);
      write_bit(4, 1'b1);
      fdf = 1'b1;
      pulse_lock();
      fdf = 1'b0;
      expect_out("fd_dlc_c", 12, EXP_FD_C, 1, EXP_FD_C, 0, 0);
      pulse_clr();
      for (int i = 1; i <= 4; i++) write_bit(i, 1'b1);
      fdf = 1'b1;
      pulse_lock();
      fdf = 1'b0;
      expect_out("fd_dlc_f", 15, EXP_FD_F, 1, EXP_FD_F, 0, 0);
      pulse_clr();
      for (int i = 1; i <= 4; i++) write_bit(i, 1'b1);
      fdf = 1'b1;
      rtr = 1'b1;
      pulse_lock();
      fdf = 1'b0;
      rtr = 1'b0;
      expect_out("fd_rtr_err", 15, 0, 1, 0, 0, int'(EXP_FD_ERR));
      pulse_clr();

      // activ held high: one write only; invalid indices are no-ops
      setidx  = IDX_W'(2);
      dlc_bit = 1'b1;
      activ   = 1'b1;
      cyc();
      dlc_bit = 1'b0;
      for (int i = 0; i < 4; i++) cyc();
      activ = 1'b0;
      cyc();
      expect_out("activ_held_once", 2, 0, 0, 0, 0, 0);
      write_bit(0, 1'b1);
      write_bit(6, 1'b1);
      write_bit(5, 1'b1);
      expect_out("setidx_invalid", 2, 0, 0, 0, 0, 0);
      pulse_lock();
      write_bit(1, 1'b1);
      expect_out("edge_in_count_ignored", 2, 2, 1, 2, 0, 0);
      pulse_lock();
      expect_out("lock_in_count_ignored", 2, 2, 1, 2, 0, 0);
      pulse_clr();

      // lock coinciding with a write edge on dlc=0
      setidx  = IDX_W'(1);
      dlc_bit = 1'b1;
      activ   = 1'b1;
      lock    = 1'b1;
      cyc();
      activ = 1'b0;
      lock  = 1'b0;
      cyc();
      expect_out("lock_drops_write", 0, 0, 1, 0, 0, 0);
      pulse_clr();

      // clr with lock
      write_bit(1, 1'b1);
      write_bit(2, 1'b1);
      clr  = 1'b1;
      lock = 1'b1;
      cyc();
      clr  = 1'b0;
      lock = 1'b0;
      expect_out("clr_beats_lock", 0, 0, 0, 0, 0, 0);
      cyc();

      // lock with byte_done in IDLE: byte_done ignored
      write_bit(1, 1'b1);
      lock      = 1'b1;
      byte_done = 1'b1;
      cyc();
      lock      = 1'b0;
      byte_done = 1'b0;
      expect_out("lock_with_byte_done", 1, 1, 1, 1, 1, 0);
      pulse_byte();
      expect_out("single_byte_done", 1, 1, 1, 0, 0, 0);
      pulse_clr();

      // Async reset mid-COUNT
      write_bit(1, 1'b1);
      write_bit(3, 1'b1);
      pulse_lock();
      pulse_byte();
      pulse_byte();
      expect_out("count_left_3", 5, 5, 1, 3, 0, 0);
      cyc();
      #2;
      reset = 1'b1;
      expect_out("async_reset_mid", 0, 0, 0, 0, 0, 0);
      cyc();
      reset = 1'b0;
      cyc();
      write_bit(2, 1'b1);
      pulse_lock();
      expect_out("fresh_lock_dlc2", 2, 2, 1, 2, 0, 0);
      pulse_byte();
      expect_out("fresh_last", 2, 2, 1, 1, 1, 0);
      pulse_byte();
      expect_out("fresh_done", 2, 2, 1, 0, 0, 0);

      cyc();
      cyc();
      if (exp_q.size() != 0) begin
         tests_run++;
         tests_failed++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
